// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

    // One counter serves all timed states, so it is sized for the longest interval.
    function automatic int pll_seq_cnt_w(
        input int unsigned hold_cycles,
        input int unsigned stable_cycles,
        input int unsigned timeout_cycles
    );
        int unsigned largest;
        int          width;
        largest = hold_cycles;
        if (stable_cycles > largest) begin
            largest = stable_cycles;
        end
        if (timeout_cycles > largest) begin
            largest = timeout_cycles;
        end
        width = $clog2(largest);
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
module pll_seq_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: hold reset, wait for lock with bounded retries, qualify, run.
// Define PLL_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RESET_HOLD_CYCLES   = 64,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int CNT_W = pll_seq_cnt_w(RESET_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                         LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    pll_seq_state_t   state;
    pll_seq_state_t   next_state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             cnt_clr;
    logic             retry_inc;
    logic             retry_clr;
    logic             loss_evt;
    logic             pll_rst_d;
    logic             ready_d;
    logic             fault_d;

    pll_seq_sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Counter, retry tally and outputs all follow the state being entered on this edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry_count <= 4'd0;
            pll_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= next_state;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == RESET_PLL || state == WAIT_LOCK || state == STABLE) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (retry_clr) begin
                retry_count <= 4'd0;
            end else if (retry_inc) begin
                retry_count <= retry_count + 4'd1;
            end
            pll_rst <= pll_rst_d;
            ready   <= ready_d;
            fault   <= fault_d;
        end
    end

    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        loss_evt   = 1'b0;
        if (relock_req) begin
            // A loss coinciding with a software relock is still counted, but re-enters once.
            next_state = RESET_PLL;
            retry_clr  = 1'b1;
            loss_evt   = (state == RUN) && !lock_s;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == HOLD_LAST) begin
                        next_state = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            next_state = FAULT;
                        end else begin
                            retry_inc  = 1'b1;
                            next_state = RESET_PLL;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        next_state = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        next_state = RUN;
                        retry_clr  = 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        loss_evt   = 1'b1;
                        next_state = RESET_PLL;
                    end
                end
                FAULT: begin
                    next_state = FAULT;
                end
                default: begin
                    next_state = RESET_PLL;
                end
            endcase
        end
    end

    assign cnt_clr = relock_req || (next_state != state);

    always_comb begin
        pll_rst_d = 1'b0;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (next_state)
            RESET_PLL: begin
                pll_rst_d = 1'b1;
            end
            RUN: begin
                ready_d = 1'b1;
            end
            FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b0;
            end
        endcase
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= 8'd0;
        end else if (loss_evt && (loss_q != LOSS_CNT_MAX)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_q;
`else
    logic loss_evt_unused;

    assign loss_evt_unused = loss_evt;
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: vector table, directed corner sequences, random run.
module tb_pll_lock_sequencer;

    localparam int HOLD = 4;
    localparam int STAB = 8;
    localparam int TMO  = 32;
    localparam int MAXR = 2;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RESET_HOLD_CYCLES   (HOLD),
        .LOCK_STABLE_CYCLES  (STAB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .relock_req      (relock_req),
        .pll_rst         (pll_rst),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    // Reference model: phase plus cycles remaining in that phase, lock seen two edges late.
    typedef enum int {M_HOLD, M_WAIT, M_QUAL, M_RUN, M_DEAD} mphase_t;
    mphase_t m_phase = M_HOLD;
    int      m_left  = HOLD;
    int      m_retry = 0;
    int      m_loss  = 0;
    bit      m_s1    = 1'b0;
    bit      m_s2    = 1'b0;

    function automatic void modelLoss();
        if (m_loss < 255) m_loss = m_loss + 1;
    endfunction

    function automatic void modelStep(bit r, bit l, bit q);
        bit ls;
        if (r) begin
            m_phase = M_HOLD; m_left = HOLD; m_retry = 0; m_loss = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = l;
        if (q) begin
            if (m_phase == M_RUN && !ls) modelLoss();
            m_phase = M_HOLD; m_left = HOLD; m_retry = 0;
            return;
        end
        case (m_phase)
            M_HOLD: begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_phase = M_WAIT; m_left = TMO; end
            end
            M_WAIT: begin
                if (ls) begin
                    m_phase = M_QUAL; m_left = STAB;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_retry == MAXR) m_phase = M_DEAD;
                        else begin m_retry = m_retry + 1; m_phase = M_HOLD; m_left = HOLD; end
                    end
                end
            end
            M_QUAL: begin
                if (!ls) begin
                    m_phase = M_WAIT; m_left = TMO;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_phase = M_RUN; m_retry = 0; end
                end
            end
            M_RUN: begin
                if (!ls) begin modelLoss(); m_phase = M_HOLD; m_left = HOLD; end
            end
            default: ;
        endcase
    endfunction

    task automatic checkVal(input string what, input logic [31:0] act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", what, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit l, input bit q);
        rst        = r;
        pll_locked = l;
        relock_req = q;
        @(posedge refclk);
        modelStep(r, l, q);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic checkOutput();
        checkVal("model_pll_rst", pll_rst, int'(m_phase == M_HOLD || m_phase == M_DEAD));
        checkVal("model_ready", ready, int'(m_phase == M_RUN));
        checkVal("model_fault", fault, int'(m_phase == M_DEAD));
        checkVal("model_retry", retry_count, m_retry);
        checkVal("model_loss", lock_loss_count, CNT_EN ? m_loss : 0);
    endtask

    task automatic step(input bit r, input bit l, input bit q);
        applyStimulus(r, l, q);
        checkOutput();
    endtask

    task automatic waitReady(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n = n + 1;
            if (ready === 1'b1) break;
        end
        checkVal("ready_reached", ready, 1);
    endtask

    task automatic lossOnce(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n = n + 1;
            if (ready === 1'b0) break;
        end
        checkVal("ready_dropped", ready, 0);
    endtask

    typedef struct {
        bit r;
        bit l;
        bit q;
        bit e_prst;
        bit e_rdy;
        bit e_flt;
        int e_retry;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int n;
        int w;
        int pulses;
        logic prev;
        int rate;
        bit lk;

        // Nominal bring-up, one row per clock: reset, 4-cycle hold, lock at row 5, ready at row 15.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{r: 1'b0, l: (i >= 5), q: 1'b0, e_prst: (i < 4), e_rdy: (i == 15),
                       e_flt: 1'b0, e_retry: 0};
        end
        tbl[0].r = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].r, tbl[i].l, tbl[i].q);
            checkVal("tbl_pll_rst", pll_rst, tbl[i].e_prst);
            checkVal("tbl_ready", ready, tbl[i].e_rdy);
            checkVal("tbl_fault", fault, tbl[i].e_flt);
            checkVal("tbl_retry", retry_count, tbl[i].e_retry);
            checkOutput();
        end

        // Nominal: hold width after release, then lock 10 cycles after release.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        w = (pll_rst === 1'b1) ? 1 : 0;
        checkVal("reset_loss_cnt", lock_loss_count, 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (pll_rst === 1'b1) w = w + 1;
        end
        checkVal("hold_width", w, HOLD);
        waitReady(n);
        checkVal("lock_to_ready", n, 3 + STAB);
        checkVal("nominal_fault", fault, 0);

        // Glitchy lock: the dropout restarts qualification without using a retry.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < HOLD + 1; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        waitReady(n);
        checkVal("glitch_to_ready", n, 3 + STAB);
        checkVal("glitch_retry", retry_count, 0);

        // Timeout: MAXR+1 reset pulses, then FAULT; relock clears it.
        step(1'b1, 1'b0, 1'b0);
        pulses = 1;
        prev = pll_rst;
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (fault === 1'b1) break;
            if (pll_rst === 1'b1 && prev === 1'b0) begin
                pulses = pulses + 1;
                checkVal("retry_at_pulse", retry_count, pulses - 1);
            end
            prev = pll_rst;
        end
        checkVal("reset_pulses", pulses, MAXR + 1);
        checkVal("fault_set", fault, 1);
        checkVal("fault_pll_rst", pll_rst, 1);
        checkVal("fault_retry", retry_count, MAXR);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        checkVal("fault_sticky", fault, 1);
        step(1'b0, 1'b0, 1'b1);
        checkVal("relock_fault_clr", fault, 0);
        checkVal("relock_pll_rst", pll_rst, 1);
        checkVal("relock_retry_clr", retry_count, 0);
        waitReady(n);

        // Lock loss in RUN: ready falls on the third edge after the drop, with pll_rst.
        lossOnce(n);
        checkVal("loss_latency", n, 3);
        checkVal("loss_pll_rst", pll_rst, 1);
        checkVal("loss_count_1", lock_loss_count, CNT_EN ? 1 : 0);
        waitReady(n);

        // Relock in the same cycle the loss is seen: one count, one hold interval.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checkVal("simul_pre_ready", ready, 1);
        step(1'b0, 1'b0, 1'b1);
        checkVal("simul_ready", ready, 0);
        checkVal("simul_pll_rst", pll_rst, 1);
        checkVal("simul_loss_cnt", lock_loss_count, CNT_EN ? 2 : 0);
        w = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (pll_rst !== 1'b1) break;
            w = w + 1;
        end
        checkVal("simul_hold_width", w, HOLD);
        waitReady(n);

        // Saturation of the loss counter.
        for (int k = 0; k < 300; k++) begin
            lossOnce(n);
            waitReady(n);
        end
        checkVal("loss_saturated", lock_loss_count, CNT_EN ? 255 : 0);

        // Reset in the middle of qualification, then a full sequence.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checkVal("midrst_pll_rst", pll_rst, 1);
        checkVal("midrst_ready", ready, 0);
        checkVal("midrst_fault", fault, 0);
        checkVal("midrst_retry", retry_count, 0);
        checkVal("midrst_loss", lock_loss_count, 0);
        waitReady(n);
        checkVal("midrst_to_ready", n, HOLD + STAB + 1);

        // Random traffic against the model, varying how often the lock flag toggles.
        lk = 1'b1;
        for (int b = 0; b < 6; b++) begin
            case (b % 3)
                0: rate = 4;
                1: rate = 25;
                default: rate = 200;
            endcase
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, rate - 1) == 0) lk = ~lk;
                step($urandom_range(0, 599) == 0, lk, $urandom_range(0, 249) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
